// File: rtl/fifo_singleclock_ext.sv
// Single-clock FIFO with programmable thresholds and an optional first-word-fall-through stage.
// Define OPTIMSOC_FIFO_ERRFLAGS_EN to build the sticky overflow/underflow flags.
module fifo_singleclock_ext #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int PROG_FULL  = DEPTH / 2,
   parameter int PROG_EMPTY = 2,
   parameter int FWFT       = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       din,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   prog_full,
   output logic [WIDTH-1:0]       dout,
   input  logic                   rd_en,
   output logic                   empty,
   output logic                   prog_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
   localparam logic [CW-1:0] PfCnt   = CW'(PROG_FULL);
   localparam logic [CW-1:0] PeCnt   = CW'(PROG_EMPTY);

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "fifo_singleclock_ext: WIDTH must be at least 1");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "fifo_singleclock_ext: DEPTH must be a power of two and at least 4");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d, ram_cnt;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] dout_q;
   logic             wr_acc, rd_acc, ram_rd;

   always_comb begin
      full    = (count_q == FullCnt);
      empty   = (FWFT != 0) ? ~out_valid_q : (count_q == '0);
      wr_acc  = wr_en & ~full;
      rd_acc  = rd_en & ~empty;
      // Words still in RAM; in FWFT mode count also covers the output stage.
      ram_cnt = count_q - CW'(out_valid_q);
      if (FWFT != 0) begin
         ram_rd      = (ram_cnt != '0) & (~out_valid_q | rd_acc);
         out_valid_d = ram_rd | (out_valid_q & ~rd_acc);
      end else begin
         ram_rd      = rd_acc;
         out_valid_d = 1'b0;
      end
      wr_ptr_d = wr_ptr_q + AW'(wr_acc);
      rd_ptr_d = rd_ptr_q + AW'(ram_rd);
      count_d  = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Array carries no reset so it maps onto block RAM; dout_q is its registered read port.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
      end else if (ram_rd) begin
         dout_q <= mem[rd_ptr_q];
      end
   end

   assign dout       = dout_q;
   assign count      = count_q;
   assign prog_full  = (count_q >= PfCnt);
   assign prog_empty = (count_q <= PeCnt);

`ifdef OPTIMSOC_FIFO_ERRFLAGS_EN
   logic overflow_q, overflow_d, underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (wr_en & full);
      underflow_d = underflow_q | (rd_en & empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_singleclock_ext.sv
// Bench for fifo_singleclock_ext: standard and FWFT instances driven in lockstep against
// queue-based reference models, with directed scenarios followed by randomized traffic.
module tb_fifo_singleclock_ext;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = 3;

   logic         clk = 1'b0;
   logic         rst, wr_en, rd_en;
   logic [W-1:0] din;

   logic s_full, s_pfull, s_empty, s_pempty, s_ovf, s_unf;
   logic f_full, f_pfull, f_empty, f_pempty, f_ovf, f_unf;
   logic [W-1:0]  s_dout, f_dout;
   logic [CW-1:0] s_count, f_count;

   always #5 clk = ~clk;

   fifo_singleclock_ext #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(s_full), .prog_full(s_pfull),
      .dout(s_dout), .rd_en(rd_en), .empty(s_empty), .prog_empty(s_pempty),
      .count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   fifo_singleclock_ext #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(f_full), .prog_full(f_pfull),
      .dout(f_dout), .rd_en(rd_en), .empty(f_empty), .prog_empty(f_pempty),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference state: whole FIFO contents as queues; FWFT head is visible once shown.
   logic [W-1:0] sq[$];
   logic [W-1:0] fq[$];
   logic [W-1:0] s_dm = '0;
   logic [W-1:0] f_dm = '0;
   bit f_shown = 1'b0;
   bit s_o = 1'b0, s_u = 1'b0, f_o = 1'b0, f_u = 1'b0;

   task automatic model_edge(input bit r, input bit we, input bit re, input logic [W-1:0] d);
      bit sfull, sempty, ffull;
      if (r) begin
         sq.delete();
         fq.delete();
         s_dm = '0;
         f_dm = '0;
         f_shown = 1'b0;
         s_o = 1'b0; s_u = 1'b0; f_o = 1'b0; f_u = 1'b0;
         return;
      end
      sfull  = (sq.size() == D);
      sempty = (sq.size() == 0);
      s_o |= we & sfull;
      s_u |= re & sempty;
      if (re && !sempty) s_dm = sq.pop_front();
      if (we && !sfull) sq.push_back(d);

      ffull = (fq.size() == D);
      f_o |= we & ffull;
      f_u |= re & !f_shown;
      if (re && f_shown) void'(fq.pop_front());
      // A word becomes visible once written at an earlier edge and at the head.
      f_shown = (fq.size() != 0);
      if (f_shown) f_dm = fq[0];
      if (we && !ffull) fq.push_back(d);
   endtask

   function automatic bit exp_flag(input bit v);
`ifdef OPTIMSOC_FIFO_ERRFLAGS_EN
      return v;
`else
      return 1'b0 & v;
`endif
   endfunction

   task automatic check_all();
      check_eq("std count", 32'(s_count), 32'(sq.size()));
      check_eq("std full", 32'(s_full), 32'(sq.size() == D));
      check_eq("std empty", 32'(s_empty), 32'(sq.size() == 0));
      check_eq("std prog_full", 32'(s_pfull), 32'(sq.size() >= D / 2));
      check_eq("std prog_empty", 32'(s_pempty), 32'(sq.size() <= 2));
      check_eq("std dout", 32'(s_dout), 32'(s_dm));
      check_eq("std overflow", 32'(s_ovf), 32'(exp_flag(s_o)));
      check_eq("std underflow", 32'(s_unf), 32'(exp_flag(s_u)));
      check_eq("fwft count", 32'(f_count), 32'(fq.size()));
      check_eq("fwft full", 32'(f_full), 32'(fq.size() == D));
      check_eq("fwft empty", 32'(f_empty), 32'(!f_shown));
      check_eq("fwft prog_full", 32'(f_pfull), 32'(fq.size() >= D / 2));
      check_eq("fwft prog_empty", 32'(f_pempty), 32'(fq.size() <= 2));
      check_eq("fwft dout", 32'(f_dout), 32'(f_dm));
      check_eq("fwft overflow", 32'(f_ovf), 32'(exp_flag(f_o)));
      check_eq("fwft underflow", 32'(f_unf), 32'(exp_flag(f_u)));
   endtask

   task automatic step(input bit r, input bit we, input bit re, input logic [W-1:0] d);
      rst   = r;
      wr_en = we;
      rd_en = re;
      din   = d;
      @(posedge clk);
      model_edge(r, we, re, d);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int facc;
      logic we, re, r;
      int wp, rp;
      logic [W-1:0] exp_rd [4];
      exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;

      step(1, 1, 1, 8'hFF);
      step(1, 0, 0, 8'h00);
      check_eq("rst std empty", 32'(s_empty), 32'd1);
      check_eq("rst fwft prog_empty", 32'(f_pempty), 32'd1);

      // Fill, overfill, drain.
      for (int i = 0; i < 4; i++) step(0, 1, 0, exp_rd[i]);
      check_eq("fill std full", 32'(s_full), 32'd1);
      check_eq("fill std count", 32'(s_count), 32'd4);
      step(0, 1, 0, 8'h55);
      check_eq("drop std count", 32'(s_count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 8'h00);
         check_eq("drain std dout", 32'(s_dout), 32'(exp_rd[i]));
      end
      check_eq("drain std empty", 32'(s_empty), 32'd1);
      step(0, 0, 1, 8'h00);

      // Single-word fall-through.
      step(1, 0, 0, 8'h00);
      step(0, 1, 0, 8'hA5);
      step(0, 0, 0, 8'h00);
      check_eq("fwft lone dout", 32'(f_dout), 32'hA5);
      check_eq("fwft lone empty", 32'(f_empty), 32'd0);
      step(0, 0, 1, 8'h00);
      check_eq("fwft lone drained", 32'(f_empty), 32'd1);
      check_eq("fwft lone count", 32'(f_count), 32'd0);

      // Simultaneous read/write on full and on empty.
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h60 + i));
      step(0, 1, 1, 8'h70);
      check_eq("full rw std count", 32'(s_count), 32'd3);
      step(1, 0, 0, 8'h00);
      step(0, 1, 1, 8'h71);
      check_eq("empty rw std count", 32'(s_count), 32'd1);

      // Continuous stream across several pointer wraps.
      step(1, 0, 0, 8'h00);
      facc = 0;
      for (int i = 0; i < 3 * D + 2; i++) begin
         if (!f_empty) facc++;
         step(0, 1, 1, 8'(8'h80 + i));
      end
      check_eq("fwft stream rate", 32'(facc), 32'(3 * D));

      // Reset mid-stream discards stored words.
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'hC0 + i));
      step(1, 1, 1, 8'hEE);
      check_eq("midrst std count", 32'(s_count), 32'd0);
      check_eq("midrst fwft empty", 32'(f_empty), 32'd1);
      step(0, 1, 0, 8'hD1);
      step(0, 0, 1, 8'h00);
      check_eq("midrst std new data", 32'(s_dout), 32'hD1);

      // Read on empty, then idle: underflow stays sticky when built in.
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h00);
      step(0, 0, 0, 8'h00);
      step(0, 1, 0, 8'h12);

      // Randomized traffic with shifting write/read bias and rare resets.
      for (int i = 0; i < 1500; i++) begin
         wp = (i < 500) ? 70 : ((i < 1000) ? 30 : 50);
         rp = 100 - wp;
         we = ($urandom_range(99) < wp);
         re = ($urandom_range(99) < rp);
         r  = ($urandom_range(199) == 0);
         step(r, we, re, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
